issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Parametrised multi-lane instruction queue between the fetch/schedule stage and the decode lanes.
- Generalises the fixed two-instruction buffer to ENQ_W write lanes, DEQ_W read lanes and DEPTH entries.
- Compacts sparse enqueue lanes, allows partial in-order dequeue, flushes on redirect and flags protocol errors with sticky bits.
- Storage is a circular buffer with registered head, tail and count.

Parameters:
INSTR_W, 64, width of one decoded instruction entry
ENQ_W, 2, enqueue lanes per cycle (1..4)
DEQ_W, 2, dequeue lanes per cycle (1..4)
DEPTH, 8, entries; power of two, DEPTH >= max(ENQ_W, DEQ_W)
CW, $clog2(DEPTH)+1, count width (derived, localparam)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all entries (jump redirect)
enq_valid  in  ENQ_W  per-lane write request; lane 0 is oldest
enq_data  in  ENQ_W*INSTR_W  lane i occupies bits [i*INSTR_W +: INSTR_W]
enq_ready  out  1  high when free slots >= ENQ_W
deq_valid  out  DEQ_W  bit i high when count > i
deq_data  out  DEQ_W*INSTR_W  entry head+i on lane i; zero when deq_valid[i]=0
deq_take  in  $clog2(DEQ_W+1)  number of oldest entries consumed this cycle
count  out  CW  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow_err  out  1  sticky: enqueue attempted while enq_ready=0
underflow_err  out  1  sticky: deq_take > valid entries

Behaviour:
- Reset (rst_n=0, asynchronous): head=0, tail=0, count=0, overflow_err=0, underflow_err=0. Outputs follow: deq_valid=0, deq_data=0, empty=1, full=0, enq_ready=1. Storage array is not reset.
- enq_ready, deq_valid, full and empty derive from registered count only. There is no combinational path from enq_valid or deq_take to any output.
- Enqueue: n_enq = popcount(enq_valid), accepted only when enq_ready=1.
  - Valid lanes are compacted in lane order: the k-th set bit (k from 0) is written to mem[(tail+k) mod DEPTH].
  - tail advances by n_enq. Pointers wrap modulo DEPTH.
- enq_valid != 0 while enq_ready=0: nothing written, state unchanged, overflow_err set.
- Dequeue: n_deq = min(deq_take, min(count, DEQ_W)). head advances by n_deq. Read is combinational from mem at head..head+DEQ_W-1, modulo DEPTH.
- deq_take greater than the number of valid lanes: clamped as above, underflow_err set.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq.
  - enq_ready is based on current count, so no freed slot is reused in the same cycle.
  - Written entries become visible on deq_data the cycle after the write edge. There is no bypass.
- flush=1 has priority over enqueue and dequeue that cycle: head=tail=count=0 at next edge.
  - Sticky error flags are also cleared on flush.
  - Enqueue lanes presented with flush are dropped and do not set overflow_err.
- Reset asserted mid-operation: immediate clear regardless of clock. Entries in flight are lost.
- Lane ordering guarantee: dequeue order equals compacted enqueue order across all wraps.

Decomposition:
- Shared package issue_pkg holds:
  - localparam defaults (INSTR_W, ENQ_W, DEQ_W, DEPTH)
  - a function popcount
  - a function wrap_add(ptr, inc) returning the pointer modulo DEPTH
- One sub-module: lane_compactor, combinational. Maps enq_valid/enq_data to a dense ordered vector plus n_enq. It is reused later by the decode-side dispatch logic.
- Storage, pointers, count and error flags stay in issue_queue.

Test Plan:
1. Reset, then enq_valid=2'b11 with data A,B for one cycle, deq_take=0 → next cycle count=2, deq_valid=2'b11, deq_data lanes = A,B, empty=0.
2. enq_valid=2'b10 with data X on lane 1 only, queue empty → next cycle deq_data lane 0 = X, deq_valid=2'b01, count=1 (compaction).
3. Fill to count=7 with DEPTH=8 → enq_ready=0. Present enq_valid=2'b01 → count stays 7, overflow_err=1 and stays 1 until flush.
4. Wrap: push 16 entries as 0..15 while taking 2 per cycle after the first push → dequeue order exactly 0..15, head and tail wrap past 7, count never exceeds 3.
5. count=1, deq_take=2 → count=0, underflow_err=1, deq_valid=0 next cycle.
6. count=5 with flush=1, enq_valid=2'b11, deq_take=2 in the same cycle → next cycle count=0, empty=1, error flags 0. Assert rst_n=0 between clock edges → outputs clear immediately.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared defaults and helpers for the multi-lane issue queue and its lane compactor.
package issue_pkg;

  localparam int INSTR_W = 64;
  localparam int ENQ_W   = 2;
  localparam int DEQ_W   = 2;
  localparam int DEPTH   = 8;

  // Number of set bits; lane vectors are at most four wide, zero-extended to eight.
  function automatic logic [3:0] popcount(input logic [7:0] vec);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + {3'd0, vec[i]};
    end
    return acc;
  endfunction

  // Circular pointer advance; depth is a power of two.
  function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned inc,
                                           input int unsigned depth);
    return (ptr + inc) % depth;
  endfunction

endpackage

// File: rtl/lane_compactor.sv
// Packs sparse valid lanes into a dense, order-preserving vector starting at lane 0.
module lane_compactor
  import issue_pkg::*;
#(
  parameter int LANES = 2,
  parameter int W     = 64
) (
  input  logic [LANES-1:0]           valid,
  input  logic [LANES*W-1:0]         data,
  output logic [LANES*W-1:0]         dense,
  output logic [$clog2(LANES+1)-1:0] n_valid
);

  assign n_valid = ($clog2(LANES+1))'(popcount(8'(valid)));

  // k-th set lane lands in dense slot k.
  always_comb begin
    int k;
    k     = 0;
    dense = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid[i]) begin
        dense[k*W +: W] = data[i*W +: W];
        k               = k + 1;
      end else begin
        k = k;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Multi-lane circular instruction queue between fetch/schedule and the decode lanes.
module issue_queue
  import issue_pkg::*;
#(
  parameter int INSTR_W = issue_pkg::INSTR_W,
  parameter int ENQ_W   = issue_pkg::ENQ_W,
  parameter int DEQ_W   = issue_pkg::DEQ_W,
  parameter int DEPTH   = issue_pkg::DEPTH,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int TW     = $clog2(DEQ_W + 1),
  localparam int EW     = $clog2(ENQ_W + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [ENQ_W-1:0]         enq_valid,
  input  logic [ENQ_W*INSTR_W-1:0] enq_data,
  output logic                     enq_ready,
  output logic [DEQ_W-1:0]         deq_valid,
  output logic [DEQ_W*INSTR_W-1:0] deq_data,
  input  logic [TW-1:0]            deq_take,
  output logic [CW-1:0]            count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  logic [INSTR_W-1:0]       mem [DEPTH];
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [ENQ_W*INSTR_W-1:0] dense;
  logic [EW-1:0]            n_enq;
  logic [CW-1:0]            avail;
  logic [CW-1:0]            n_deq;
  logic [CW-1:0]            n_acc;
  logic                     enq_fire;
  logic                     take_over;

  lane_compactor #(.LANES(ENQ_W), .W(INSTR_W)) u_compactor (
    .valid   (enq_valid),
    .data    (enq_data),
    .dense   (dense),
    .n_valid (n_enq)
  );

  // Status comes only from registered count, keeping inputs off the output paths.
  assign enq_ready = (count <= CW'(DEPTH - ENQ_W));
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == {CW{1'b0}});

  assign avail     = (count < CW'(DEQ_W)) ? count : CW'(DEQ_W);
  assign take_over = (CW'(deq_take) > avail);
  assign n_deq     = take_over ? avail : CW'(deq_take);
  assign enq_fire  = enq_ready && !flush;
  assign n_acc     = enq_fire ? CW'(n_enq) : {CW{1'b0}};

  // Combinational read of the oldest DEQ_W entries; invalid lanes read as zero.
  always_comb begin
    deq_data = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_valid[i] = (count > CW'(i));
      if (deq_valid[i]) begin
        deq_data[i*INSTR_W +: INSTR_W] = mem[PW'(wrap_add(32'(head), i, DEPTH))];
      end else begin
        deq_data[i*INSTR_W +: INSTR_W] = '0;
      end
    end
  end

  // Storage write of compacted lanes; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_W; k++) begin
      if (enq_fire && (k < int'(n_enq))) begin
        mem[PW'(wrap_add(32'(tail), k, DEPTH))] <= dense[k*INSTR_W +: INSTR_W];
      end
    end
  end

  // Pointers, occupancy and sticky error flags; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      head          <= PW'(wrap_add(32'(head), 32'(n_deq), DEPTH));
      tail          <= PW'(wrap_add(32'(tail), 32'(n_acc), DEPTH));
      count         <= count + n_acc - n_deq;
      overflow_err  <= overflow_err | ((|enq_valid) & ~enq_ready);
      underflow_err <= underflow_err | take_over;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with default parameters (2 lanes each way, depth 8).
module tb_issue_queue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [1:0]   enq_valid;
  logic [127:0] enq_data;
  logic         enq_ready;
  logic [1:0]   deq_valid;
  logic [127:0] deq_data;
  logic [1:0]   deq_take;
  logic [3:0]   count;
  logic         full;
  logic         empty;
  logic         overflow_err;
  logic         underflow_err;

  int tests  = 0;
  int failed = 0;

  issue_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .enq_valid     (enq_valid),
    .enq_data      (enq_data),
    .enq_ready     (enq_ready),
    .deq_valid     (deq_valid),
    .deq_data      (deq_data),
    .deq_take      (deq_take),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] A = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] B = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] X = 64'h1234_5678_9ABC_DEF0;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    enq_valid = 2'b00;
    enq_data  = 128'd0;
    deq_take  = 2'd0;
    #2;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_full", 128'(full), 128'd0);
    chk("rst_ready", 128'(enq_ready), 128'd1);
    chk("rst_dvalid", 128'(deq_valid), 128'd0);
    chk("rst_ddata", deq_data, 128'd0);
    chk("rst_errs", 128'({overflow_err, underflow_err}), 128'd0);
    #10;
    rst_n = 1'b1;
    step();

    // 1: two lanes in
    enq_valid = 2'b11;
    enq_data  = {B, A};
    step();
    enq_valid = 2'b00;
    chk("t1_count", 128'(count), 128'd2);
    chk("t1_dvalid", 128'(deq_valid), 128'd3);
    chk("t1_ddata", deq_data, {B, A});
    chk("t1_empty", 128'(empty), 128'd0);

    // 2: compaction of lane 1 into slot 0
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t2_flushed", 128'(count), 128'd0);
    enq_valid = 2'b10;
    enq_data  = {X, 64'hDEAD_BEEF_DEAD_BEEF};
    step();
    enq_valid = 2'b00;
    chk("t2_ddata", deq_data, {64'd0, X});
    chk("t2_dvalid", 128'(deq_valid), 128'd1);
    chk("t2_count", 128'(count), 128'd1);

    // 3: fill to 7, then overflow
    for (int i = 0; i < 3; i++) begin
      enq_valid = 2'b11;
      enq_data  = {64'(2*i + 101), 64'(2*i + 100)};
      step();
    end
    enq_valid = 2'b00;
    chk("t3_count7", 128'(count), 128'd7);
    chk("t3_ready", 128'(enq_ready), 128'd0);
    chk("t3_notfull", 128'(full), 128'd0);
    chk("t3_head", deq_data, {64'd100, X});
    enq_valid = 2'b01;
    enq_data  = {64'd0, 64'd999};
    step();
    enq_valid = 2'b00;
    chk("t3_count_hold", 128'(count), 128'd7);
    chk("t3_ovf", 128'(overflow_err), 128'd1);
    step();
    chk("t3_ovf_sticky", 128'(overflow_err), 128'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_ovf_clr", 128'(overflow_err), 128'd0);
    chk("t3_cnt_clr", 128'(count), 128'd0);

    // 4: 16 entries streamed through, wrapping both pointers
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        enq_valid = 2'b11;
        enq_data  = {64'(2*c + 1), 64'(2*c)};
      end else begin
        enq_valid = 2'b00;
      end
      deq_take = (c == 0) ? 2'd0 : 2'd2;
      if (c > 0) begin
        chk("t4_order", deq_data, {64'(2*c - 1), 64'(2*c - 2)});
        chk("t4_dvalid", 128'(deq_valid), 128'd3);
        chk("t4_maxcnt", 128'(count <= 4'd3), 128'd1);
      end
      step();
    end
    enq_valid = 2'b00;
    deq_take  = 2'd0;
    chk("t4_drained", 128'(count), 128'd0);
    chk("t4_empty", 128'(empty), 128'd1);
    chk("t4_no_err", 128'({overflow_err, underflow_err}), 128'd0);

    // 5: underflow on over-take
    enq_valid = 2'b01;
    enq_data  = {64'd0, 64'h5A};
    step();
    enq_valid = 2'b00;
    chk("t5_count1", 128'(count), 128'd1);
    chk("t5_wrapped_data", deq_data, {64'd0, 64'h5A});
    deq_take = 2'd2;
    step();
    deq_take = 2'd0;
    chk("t5_count0", 128'(count), 128'd0);
    chk("t5_udf", 128'(underflow_err), 128'd1);
    chk("t5_dvalid", 128'(deq_valid), 128'd0);

    // 6: flush wins over enqueue and dequeue, then async reset
    for (int i = 0; i < 3; i++) begin
      enq_valid = (i == 2) ? 2'b01 : 2'b11;
      enq_data  = {64'(i + 50), 64'(i + 40)};
      step();
    end
    enq_valid = 2'b00;
    chk("t6_count5", 128'(count), 128'd5);
    flush     = 1'b1;
    enq_valid = 2'b11;
    deq_take  = 2'd2;
    step();
    flush     = 1'b0;
    enq_valid = 2'b00;
    deq_take  = 2'd0;
    chk("t6_count", 128'(count), 128'd0);
    chk("t6_empty", 128'(empty), 128'd1);
    chk("t6_errs", 128'({overflow_err, underflow_err}), 128'd0);
    chk("t6_ready", 128'(enq_ready), 128'd1);
    enq_valid = 2'b11;
    enq_data  = {B, A};
    step();
    enq_valid = 2'b00;
    chk("t6_refill", 128'(count), 128'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_count", 128'(count), 128'd0);
    chk("t6_arst_dvalid", 128'(deq_valid), 128'd0);
    chk("t6_arst_ddata", deq_data, 128'd0);
    chk("t6_arst_empty", 128'(empty), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
